// File: rtl/pw_layer_sched.sv
// pw_layer_sched: sequences one pointwise-conv layer pass over a cols x rows feature map.
// Pixels are accepted from upstream and issued to a 1-cycle-latency datapath. Results go
// through a 2-entry FIFO to the downstream port. Credit-based input throttling means the
// FIFO never overflows when the datapath behaves.
// Optional build macro: PW_LAYER_SCHED_PERF_EN adds the perf_stall counter output.
// Ports:
//   clk, rst                      clock, async active-high reset
//   start, cfg_cols, cfg_rows     pass launch and map dimensions (latched in IDLE)
//   in_valid/in_ready/in_data     upstream pixel handshake
//   dp_valid/dp_act               issue to datapath
//   dp_ready/dp_out               datapath result (one cycle after issue)
//   out_valid/out_ready/out_data  downstream result handshake, out_last on final pixel
//   busy, done, err_ovf           status; perf_stall with PW_LAYER_SCHED_PERF_EN
module pw_layer_sched #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 128,
  parameter int unsigned DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_cols,
  input  logic [DIM_W-1:0] cfg_rows,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             dp_valid,
  output logic [IN_W-1:0]  dp_act,
  input  logic             dp_ready,
  input  logic [OUT_W-1:0] dp_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
`ifdef PW_LAYER_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_stall
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [DIM_W-1:0] cols_q, rows_q, col_q, row_q;
  logic [15:0]      total_q, out_cnt_q;
  logic             inflight_q;
  logic [OUT_W-1:0] fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic [IN_W-1:0]  act_q;
  logic             err_ovf_q;

  logic        pop, push, issue, fifo_full, col_wrap, last_issue;
  logic [2:0]  occ;
  logic [15:0] prod;

  assign prod      = 16'(cfg_cols) * 16'(cfg_rows);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign pop       = out_valid & out_ready;
  assign fifo_full = (count_q == 2'd2);
  // Credits: results held plus the one in flight, minus the one leaving this cycle.
  assign occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign in_ready  = (state_q == StRun) && (occ < 3'd2);
  assign issue     = in_valid & in_ready;
  assign dp_valid  = issue;
  assign dp_act    = issue ? in_data : act_q;
  // A full FIFO can still take a result if the head leaves in the same cycle.
  assign push      = dp_ready & ~(fifo_full & ~pop);
  assign col_wrap  = (col_q == cols_q - DIM_W'(1));
  assign last_issue = issue && col_wrap && (row_q == rows_q - DIM_W'(1));
  assign out_last  = out_valid && ((out_cnt_q + 16'd1) == total_q);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err_ovf   = err_ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cols_q     <= '0;
      rows_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      total_q    <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      act_q      <= '0;
      err_ovf_q  <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) act_q <= in_data;

      if (push) begin
        fifo_q[wr_ptr_q] <= dp_out;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
      if (dp_ready && fifo_full && !pop) err_ovf_q <= 1'b1;
      if (pop) out_cnt_q <= out_cnt_q + 16'd1;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            cols_q    <= cfg_cols;
            rows_q    <= cfg_rows;
            total_q   <= prod;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
            state_q   <= ((cfg_cols == '0) || (cfg_rows == '0)) ? StDone : StRun;
          end
        end
        StRun: begin
          if (issue) begin
            if (col_wrap) begin
              col_q <= '0;
              row_q <= row_q + DIM_W'(1);
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
            if (last_issue) state_q <= StDrain;
          end
        end
        StDrain: begin
          if ((count_q == 2'd0) && !inflight_q && (out_cnt_q == total_q)) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PW_LAYER_SCHED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && in_valid && !in_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall = stall_q;
`endif

endmodule
